// File: rtl/eth_tx_fifo_reader_if.sv
// Bundle between the tx FIFO reader and its neighbours. The controller
// drives start/frame_len, the async FIFO drives empty/data, and the GMII side
// consumes tx_en/tx_er/txd.
interface eth_tx_fifo_reader_if #(
    parameter int LEN_W = 11
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic             done;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_rd_en;
    logic             tx_en;
    logic             tx_er;
    logic [7:0]       txd;
    logic             underrun;

    // Environment side: requests frames, owns the FIFO, observes the byte stream.
    modport master (
        output start, frame_len, fifo_empty, fifo_data,
        input  busy, done, fifo_rd_en, tx_en, tx_er, txd, underrun
    );

    // Reader side.
    modport slave (
        input  start, frame_len, fifo_empty, fifo_data,
        output busy, done, fifo_rd_en, tx_en, tx_er, txd, underrun
    );
endinterface

// File: rtl/eth_tx_fifo_reader.sv
// Read-side consumer of the encapsulation FIFO. For each start request it
// emits preamble, SFD, the frame payload drained from the FIFO, zero padding
// up to MIN_LEN, then holds off for IFG_LEN idle byte-times. A FIFO that runs
// dry mid-payload ends the frame with a single tx_er byte.
module eth_tx_fifo_reader #(
    parameter int PTR_LEN = 3,
    parameter int MIN_LEN = 60,
    parameter int IFG_LEN = 12,
    parameter int LEN_W   = 11
) (
    input  logic                 rclk,
    input  logic                 rd_srst,
    eth_tx_fifo_reader_if.slave  bus
);

    // Counters share one LEN_W register, so both MIN_LEN and IFG_LEN must fit.
    if (PTR_LEN < 1 || MIN_LEN < 1 || IFG_LEN < 1 ||
        MIN_LEN > (1 << LEN_W) || IFG_LEN > (1 << LEN_W)) begin : g_bad_params
        $error("eth_tx_fifo_reader: parameter out of range");
    end

    localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(6);
    localparam logic [LEN_W-1:0] PAD_LAST  = LEN_W'(MIN_LEN - 1);
    localparam logic [LEN_W-1:0] IFG_LAST  = LEN_W'(IFG_LEN - 1);
    localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_PAY, S_PAD, S_ERR, S_IFG
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic [7:0]       txd_q, txd_d;
    logic             pay_sel_q, pay_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             rd_sched_q, rd_sched_d;

    logic [LEN_W-1:0] pay_last;
    logic             rd_miss;

    // Only used while len_q > 0, so the decrement never wraps.
    assign pay_last = len_q - LEN_W'(1);
    // A read was due this cycle but the FIFO had nothing to give.
    assign rd_miss  = rd_sched_q & bus.fifo_empty;

    // Next state, byte counter and the registered outputs for the next cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        txd_d      = 8'h00;
        pay_sel_d  = 1'b0;
        underrun_d = 1'b0;
        done_d     = 1'b0;
        rd_sched_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    len_d   = bus.frame_len;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_SFD: begin
                cnt_d = '0;
                if (len_q == '0)  state_d = S_PAD;
                else if (rd_miss) state_d = S_ERR;
                else              state_d = S_PAY;
            end
            S_PAY: begin
                if (rd_miss) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else if (cnt_q == pay_last) begin
                    if (len_q >= MIN_LEN_W) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end else begin
                        // Padding continues the byte count up to MIN_LEN.
                        state_d = S_PAD;
                        cnt_d   = cnt_q + LEN_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_PAD: begin
                if (cnt_q == PAD_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            S_ERR: begin
                state_d = S_IFG;
                cnt_d   = '0;
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            S_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h55;
            end
            S_SFD: begin
                tx_en_d    = 1'b1;
                txd_d      = 8'hD5;
                // First read issued here so byte 0 is on fifo_data in PAY.
                rd_sched_d = (len_d != '0);
            end
            S_PAY: begin
                tx_en_d    = 1'b1;
                pay_sel_d  = 1'b1;
                // One read ahead: the last payload byte needs no new read.
                rd_sched_d = (cnt_d < pay_last);
            end
            S_PAD: begin
                tx_en_d = 1'b1;
            end
            S_ERR: begin
                tx_en_d    = 1'b1;
                tx_er_d    = 1'b1;
                underrun_d = 1'b1;
            end
            S_IFG: begin
                done_d = (cnt_d == IFG_LAST);
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge rclk) begin
        if (rd_srst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            txd_q      <= 8'h00;
            pay_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            rd_sched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            txd_q      <= txd_d;
            pay_sel_q  <= pay_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            rd_sched_q <= rd_sched_d;
        end
    end

    // Payload bytes come straight off the FIFO's registered read port under a
    // registered select; re-registering them would break the one-ahead read
    // schedule. The read strobe is gated live so an empty FIFO is never popped.
    assign bus.txd        = pay_sel_q ? bus.fifo_data : txd_q;
    assign bus.fifo_rd_en = rd_sched_q & ~bus.fifo_empty;
    assign bus.tx_en      = tx_en_q;
    assign bus.tx_er      = tx_er_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;

endmodule
